// File: rtl/display_arbiter.sv
// Two-requester arbiter for a 4-digit multiplexed 7-seg display.
// Ownership changes only at frame boundaries; anode/digit are registered with the scan.
module display_arbiter #(
  parameter int unsigned HOLD_FRAMES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic [1:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  output logic [1:0]  gnt,
  output logic [3:0]  anode,
  output logic [3:0]  digit,
  output logic        frame_done
);

  localparam logic [7:0] HOLD = 8'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic [7:0]  r_frames, w_frames_nxt;
  logic        r_ptr, w_ptr_nxt;
  logic [3:0]  r_anode, r_digit;
  logic        r_frame_done;

  logic        w_own, w_own_req, w_oth_req, w_frame_end, w_pick;
  logic [7:0]  w_frames_inc;
  logic [15:0] w_data;
  logic [3:0]  w_anode_nxt, w_digit_nxt;

  assign w_own        = (r_state == OWN1);
  assign w_own_req    = req[w_own];
  assign w_oth_req    = req[~w_own];
  assign w_frame_end  = (r_state != IDLE) && tick && (r_idx == 2'd3);
  assign w_frames_inc = (r_frames >= HOLD) ? HOLD : r_frames + 8'd1;

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_frames_nxt = r_frames;
    w_ptr_nxt    = r_ptr;
    w_pick       = 1'b0;
    case (r_state)
      IDLE: begin
        if (req != 2'b00) begin
          // pointer names the requester that wins a tie
          w_pick       = (req == 2'b11) ? r_ptr : req[1];
          w_state_nxt  = w_pick ? OWN1 : OWN0;
          w_idx_nxt    = 2'd0;
          w_frames_nxt = 8'd0;
          w_ptr_nxt    = ~w_pick;
        end
      end
      OWN0, OWN1: begin
        if (tick) begin
          w_idx_nxt = r_idx + 2'd1;
          if (w_frame_end) begin
            w_frames_nxt = w_frames_inc;
            if (w_oth_req && (!w_own_req || w_frames_inc >= HOLD)) begin
              w_state_nxt  = w_own ? OWN0 : OWN1;
              w_frames_nxt = 8'd0;
              w_ptr_nxt    = w_own;
            end else if (!w_own_req) begin
              w_state_nxt  = IDLE;
              w_frames_nxt = 8'd0;
            end
          end
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_idx_nxt    = 2'd0;
        w_frames_nxt = 8'd0;
      end
    endcase
  end

  // Outputs are computed from the next state so they land on the same edge.
  assign w_data = (w_state_nxt == OWN1) ? data1 : data0;

  always_comb begin
    w_anode_nxt = 4'hf;
    w_digit_nxt = 4'h0;
    if (w_state_nxt != IDLE) begin
      w_anode_nxt = ~(4'b0001 << w_idx_nxt);
      w_digit_nxt = w_data[{w_idx_nxt, 2'b00} +: 4];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_idx        <= 2'd0;
      r_frames     <= 8'd0;
      r_ptr        <= 1'b0;
      r_anode      <= 4'hf;
      r_digit      <= 4'h0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_frames     <= w_frames_nxt;
      r_ptr        <= w_ptr_nxt;
      r_anode      <= w_anode_nxt;
      r_digit      <= w_digit_nxt;
      r_frame_done <= w_frame_end;
    end
  end

  assign gnt        = {r_state == OWN1, r_state == OWN0};
  assign anode      = r_anode;
  assign digit      = r_digit;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter: a frame-level model queues expected outputs
// each edge and an independent monitor pops and compares them.
module tb_display_arbiter;
  localparam int HOLD = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tick  = 1'b0;
  logic [1:0]  req   = 2'b00;
  logic [15:0] data0 = 16'h0;
  logic [15:0] data1 = 16'h0;
  logic [1:0]  gnt;
  logic [3:0]  anode, digit;
  logic        frame_done;

  display_arbiter #(.HOLD_FRAMES(HOLD)) dut (
    .clock(clock), .reset(reset), .tick(tick), .req(req),
    .data0(data0), .data1(data1), .gnt(gnt), .anode(anode),
    .digit(digit), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] gnt;
    logic [3:0] anode;
    logic [3:0] digit;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // reference state: owner (-1 idle), slot in frame, frames completed, favoured requester
  int m_own = -1, m_slot = 0, m_frames = 0, m_fav = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin : model
    exp_t e;
    int oth;
    logic [15:0] dd;
    logic fd;
    fd = 1'b0;
    if (reset) begin
      m_own = -1; m_slot = 0; m_frames = 0; m_fav = 0;
    end else if (m_own < 0) begin
      if (req != 2'b00) begin
        m_own    = (req == 2'b11) ? m_fav : (req[1] ? 1 : 0);
        m_fav    = 1 - m_own;
        m_slot   = 0;
        m_frames = 0;
      end
    end else if (tick) begin
      if (m_slot < 3) m_slot++;
      else begin
        fd  = 1'b1;
        m_frames++;
        oth = 1 - m_own;
        if (req[oth] && (!req[m_own] || m_frames >= HOLD)) begin
          m_fav = m_own; m_own = oth; m_frames = 0;
        end else if (!req[m_own]) begin
          m_own = -1;
        end
        m_slot = 0;
      end
    end
    if (m_own < 0) begin
      e.gnt = 2'b00; e.anode = 4'hf; e.digit = 4'h0;
    end else begin
      dd      = (m_own == 1) ? data1 : data0;
      e.gnt   = (m_own == 1) ? 2'b10 : 2'b01;
      e.anode = ~(4'b0001 << m_slot);
      e.digit = 4'((dd >> (4 * m_slot)) & 16'hf);
    end
    e.fd = fd;
    q.push_back(e);
  end

  always @(posedge clock) begin : monitor
    exp_t e;
    #1;
    if (q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected >=1 at %0t", $time);
    end else begin
      e = q.pop_front();
      chk("gnt", 16'(gnt), 16'(e.gnt));
      chk("anode", 16'(anode), 16'(e.anode));
      chk("digit", 16'(digit), 16'(e.digit));
      chk("frame_done", 16'(frame_done), 16'(e.fd));
    end
  end

  task automatic step(input logic t, input logic [1:0] r);
    tick = t;
    req  = r;
    @(negedge clock);
  endtask

  // Reset asserted between edges must clear outputs without a clock.
  task automatic pulse_reset(input logic [1:0] r_after);
    #2 reset = 1'b1;
    #1;
    chk("async_gnt", 16'(gnt), 16'h0);
    chk("async_anode", 16'(anode), 16'hf);
    chk("async_digit", 16'(digit), 16'h0);
    chk("async_fd", 16'(frame_done), 16'h0);
    tick = 1'b0;
    req  = r_after;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // single requester, slow tick
    data0 = 16'h4321; data1 = 16'h8765;
    step(0, 2'b01);
    step(1, 2'b01);
    repeat (12) begin
      step(1, 2'b01); step(0, 2'b01); step(0, 2'b01);
    end
    step(0, 2'b00);

    // simultaneous requests, hold expiry swaps owners
    pulse_reset(2'b11);
    step(0, 2'b11);
    repeat (20) step(1, 2'b11);

    // owner 0 drops mid-frame; frame still completes before handover
    pulse_reset(2'b11);
    step(0, 2'b11);
    step(1, 2'b11);
    repeat (10) step(1, 2'b10);

    // long single ownership: counter saturates, frame_done every frame
    pulse_reset(2'b00);
    step(0, 2'b01);
    repeat (1200) step(1, 2'b01);
    repeat (8) begin
      data0 = 16'($urandom);
      step(0, 2'b01);
    end

    // reset while anode = 1011, then restart with requester 1
    pulse_reset(2'b00);
    step(0, 2'b01);
    step(1, 2'b01);
    step(1, 2'b01);
    pulse_reset(2'b10);
    repeat (6) step(1, 2'b10);
    step(1, 2'b11);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      data0 = 16'($urandom);
      data1 = 16'($urandom);
      if ($urandom_range(0, 199) == 0) pulse_reset(2'($urandom_range(0, 3)));
      else step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end

    @(posedge clock);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 SHALL have parameter HOLD_FRAMES, default 4: the minimum number of complete scan frames an owner keeps the display; legal range 1..255.
REQ-002 SHALL have port clock, input, 1: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port tick, input, 1: scan-advance enable from the clock divider; a one-clock pulse per digit slot.
REQ-005 SHALL have port req, input, 2: req[i] high means requester i wants the display.
REQ-006 SHALL have port data0, input, 16: four hex nibbles from requester 0; data0[3:0] is digit 0 (rightmost).
REQ-007 SHALL have port data1, input, 16: four hex nibbles from requester 1, same layout as data0.
REQ-008 SHALL have port gnt, output, 2: one-hot current owner; 2'b00 when idle.
REQ-009 SHALL have port anode, output, 4: active-low digit enable to the display.
REQ-010 SHALL have port digit, output, 4: nibble for the 7-seg decoder.
REQ-011 SHALL have port frame_done, output, 1: one-clock pulse when an owned frame completes.

Function
REQ-012 SHALL implement a state machine with states IDLE, OWN0 and OWN1; gnt SHALL be 00, 01 and 10 in those states respectively.
REQ-013 SHALL keep a 2-bit scan index and a frame counter; a frame is four ticks covering scan index 0..3.
REQ-014 In IDLE, with req != 0, SHALL enter the selected OWNx on the next edge without waiting for tick, with scan index 0 and frame counter 0.
REQ-015 SHALL use a priority pointer for simultaneous requests: the requester not most recently granted wins; the pointer favours requester 0 after reset.
REQ-016 In OWNx, SHALL advance the scan index by 1 on each tick only, wrapping from 3 to 0.
REQ-017 SHALL treat a tick at scan index 3 as the frame end; frame_done SHALL be high for the cycle after that edge.
REQ-018 SHALL make ownership decisions only at frame end; a requester that drops req mid-frame still has its frame completed, never truncated.
REQ-019 At frame end, SHALL increment the frame counter, saturating at HOLD_FRAMES.
REQ-020 At frame end, once the owner has held HOLD_FRAMES frames and the other requester is requesting, SHALL switch to the other owner on that edge (scan index 0, counter 0).
REQ-021 At frame end, if the owner's req is low, SHALL switch to the other owner if it is requesting, regardless of hold count; otherwise it SHALL go to IDLE.
REQ-022 At frame end, if the owner still requests and the other does not, SHALL keep the current owner.
REQ-023 SHALL drive anode registered, one-hot-low per scan index: 0 gives 1110, 1 gives 1101, 2 gives 1011, 3 gives 0111; anode SHALL be 1111 in IDLE.
REQ-024 SHALL register digit every cycle as owner_data[4*idx+3 : 4*idx], so a data change appears one clock later; digit SHALL be 0000 in IDLE.
REQ-025 SHALL update anode and digit on the same edge as the scan index or state change; there is no extra latency.
REQ-026 SHALL ignore a tick arriving in IDLE; req changes alone SHALL not move the scan index.

Reset
REQ-027 While reset is high, SHALL hold state IDLE, gnt=00, anode=1111, digit=0000, frame_done=0, scan index 0, frame counter 0 and pointer favouring requester 0.
REQ-028 Reset asserted mid-frame SHALL take effect immediately, without waiting for clock or tick; after release, arbitration restarts as if from power-up.

Verification
REQ-029 Reset, then req=01 and data0=16'h4321 -> gnt=01 one clock later; anode/digit follow the sequence 1110/1, 1101/2, 1011/3, 0111/4 on successive ticks.
REQ-030 Both requests raised in the same cycle from reset -> requester 0 is granted; with HOLD_FRAMES=2, gnt changes to 10 exactly at the 2nd frame_done edge.
REQ-031 Owner 0 drops req at scan index 1 of its first frame while req1=1 -> remaining digits 2 and 3 are still shown, then gnt=10 at frame end despite hold=1 of 4.
REQ-032 Only req0 asserted for 300 frames -> gnt stays 01, the frame counter saturates and frame_done pulses each frame.
REQ-033 Reset pulsed while anode=1011 -> anode=1111, gnt=00 and digit=0000 asynchronously; after release with req=10 -> gnt=10.
